input_port_fifo: RTL

Input-direction peripheral for the simple machine's I/O bus: the read-side counterpart to the write-enabled output register. It accepts 16-bit words from an external producer via a strobe that may be asynchronous to `clk`. It synchronizes the strobe, captures each word into a small FIFO, and presents the oldest word plus status flags to the CPU, which consumes words with a one-cycle read pulse.

---
 rtl/input_port_fifo_if.sv | 28 ++
 rtl/input_port_fifo.sv | 71 +++++++
 2 files changed

// File: rtl/input_port_fifo_if.sv
// Bus between the external producer/CPU and the input-port FIFO.
// master drives data, strobe and CPU controls; slave (the FIFO) returns word and status.
interface input_port_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] dataIn;
    logic             strobeIn;
    logic             readEnable;
    logic             clearOverflow;
    logic [WIDTH-1:0] dataOut;
    logic             dataValid;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;

    modport master (
        output dataIn, strobeIn, readEnable, clearOverflow,
        input  dataOut, dataValid, full, count, overflow
    );

    modport slave (
        input  dataIn, strobeIn, readEnable, clearOverflow,
        output dataOut, dataValid, full, count, overflow
    );
endinterface

// File: rtl/input_port_fifo.sv
// Synchronizes an async write strobe and queues captured words for CPU reads; capture lands 2 edges
// after the strobe is first sampled, reads pop in one cycle. No backpressure: a push into a full FIFO is dropped and flagged.
module input_port_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input logic              clk,
    input logic              reset,
    input_port_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             overflowFlag;
    logic             s1;
    logic             s2;
    logic             s2d;
    logic             rise;
    logic             pop;
    logic             push;
    logic             drop;

    // Chain resets high so a strobe already asserted at release is not seen as an edge.
    assign rise = s2 & ~s2d;
    assign pop  = bus.readEnable && (cnt != '0);
    assign push = rise && ((cnt != FULL_COUNT) || pop);
    assign drop = rise && (cnt == FULL_COUNT) && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1           <= 1'b1;
            s2           <= 1'b1;
            s2d          <= 1'b1;
            wp           <= '0;
            rp           <= '0;
            cnt          <= '0;
            overflowFlag <= 1'b0;
        end else begin
            s1  <= bus.strobeIn;
            s2  <= s1;
            s2d <= s2;
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A drop in the same cycle as a clear must leave the flag set.
            if (drop)
                overflowFlag <= 1'b1;
            else if (bus.clearOverflow)
                overflowFlag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= bus.dataIn;
    end

    assign bus.dataValid = (cnt != '0);
    assign bus.full      = (cnt == FULL_COUNT);
    assign bus.count     = cnt;
    assign bus.overflow  = overflowFlag;
    assign bus.dataOut   = bus.dataValid ? mem[rp] : '0;
endmodule
